hbf7_interp2: RTL and testbench
===============================

// Module: hbf7_interp2
// PURPOSE
//  2x upsampling interpolator built on the 7-tap half-band prototype
//  (h = -2,0,34,64,34,0,-2). It is the expansion side of the half-band path.
//  It takes signed samples at rate Fs on a valid/ready stream and emits 2 samples
//  per input at 2*Fs on a valid/ready stream. Polyphase form: 4-tap even branch,
//  1-tap odd branch.
// PARAMETERS
//  DW     8   input sample width, signed two's complement
//  OW     16  output sample width, signed; full-precision sum fits for DW=8
//  SHIFT  0   arithmetic right shift applied to each sum before output (truncating)
// PORTS
//  clk        in   1   single clock, all state on posedge
//  rst_n      in   1   asynchronous, active-low reset
//  in_valid   in   1   in_data is valid this cycle
//  in_ready   out  1   block accepts in_data this cycle
//  in_data    in   DW  signed input sample x[n]
//  out_valid  out  1   out_data is valid this cycle
//  out_ready  in   1   downstream accepts out_data this cycle
//  out_data   out  OW  signed interpolated sample y[m]
// BEHAVIOUR
//  - Reset (async, rst_n=0): state=IDLE, tap line xQ[0..3]=0, out_data=0, out_valid=0.
//    in_ready=1 after release. Reset mid-burst discards any pending outputs.
//  - Accept = in_valid & in_ready. Transfer = out_valid & out_ready.
//  - On accept: xQ[0]<=in_data, xQ[i]<=xQ[i-1]. Even sum is computed from the
//    shifted line: y[2n] = -2*x[n] + 34*x[n-1] + 34*x[n-2] - 2*x[n-3].
//    It is registered to out_data.
//  - Odd sample: y[2n+1] = 64*x[n-1] (the zero taps h1,h5 are not built).
//  - FSM:
//    IDLE: out_valid=0, in_ready=1; accept -> EVEN.
//    EVEN: out_valid=1 with y[2n], in_ready=0; transfer -> load y[2n+1] -> ODD;
//          no transfer -> hold.
//    ODD:  out_valid=1 with y[2n+1], in_ready=out_ready.
//          transfer & accept -> load new y[2n+2] -> EVEN.
//          transfer & no accept -> IDLE.
//          no transfer -> hold.
//  - Latency: accept at cycle t -> even output valid at t+1, odd at t+2 at the earliest.
//    Sustained throughput is 1 output/clk (1 input per 2 clk).
//  - Backpressure: out_data and out_valid stay stable while out_valid & !out_ready.
//    Tap line never shifts without an accept.
//  - Arithmetic: products DW+8 bits signed; sums are accumulated at OW bits.
//    Neither branch can overflow for DW=8: worst case |sum| is 72*128 = 9216.
//    out_data = sum >>> SHIFT, with no rounding and no saturation.
//  - DC gain is 64 per phase, so a constant input x gives output 64*x >>> SHIFT.
// STRUCTURE
//  - Package hbf7_pkg holds the coefficient localparams HB_C0=-2, HB_C2=34,
//    HB_C3=64 and the state enum typedef hbf7_state_e {IDLE, EVEN, ODD}.
//    The FIR filter and the future decimator share this package.
//  - One sub-module, hbf7_tap_line: a 4-deep signed DW shift register with
//    enable (accept) and async clear. It exposes xQ[0..3].
//  - Top level contains the FSM, the even and odd adders, and the output register.
// TESTING
//  1. Impulse: after reset, feed 64 then 0s, out_ready=1. out_data must be
//     -128, 0, 2176, 4096, 2176, 0, -128, 0, then 0s.
//  2. Full rate: in_valid=1 with ramp 1,2,3..., out_ready=1. in_ready must
//     toggle 1,0. out_valid must be continuous from t+1. Every 2nd output
//     equals 64*x[n-1].
//  3. Backpressure: drop out_ready for 3 clk while in EVEN. out_data and
//     out_valid must be held, in_ready=0, and the tap line unchanged. Resume
//     and check the sequence matches case 1.
//  4. Extremes: constant -128 -> steady outputs -8192; constant 127 -> 8128.
//     No wrap on any output.
//  5. Reset mid-burst: assert rst_n=0 while in ODD. out_valid must drop
//     immediately. After release, the impulse of case 1 must reproduce
//     exactly, with no residue from older samples.
//  6. SHIFT=6 build: repeat case 1. Expected -2, 0, 34, 64, 34, 0, -2.

Source files
------------

// File: rtl/hbf7_pkg.sv
// Shared constants and types for the 7-tap half-band filter family
// (FIR, 2x interpolator, 2x decimator).
package hbf7_pkg;

    // Non-zero prototype taps: h = C0, 0, C2, C3, C2, 0, C0
    localparam int signed HB_C0 = -2;
    localparam int signed HB_C2 = 34;
    localparam int signed HB_C3 = 64;

    typedef enum logic [1:0] {
        IDLE,
        EVEN,
        ODD
    } hbf7_state_e;

endpackage

// File: rtl/hbf7_tap_line.sv
// Four-deep signed sample delay line; shifts only when en is high.
// xq[0] holds the newest sample.
module hbf7_tap_line #(
    parameter int unsigned DW = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    input  logic signed [DW-1:0] din,
    output logic signed [DW-1:0] xq [4]
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) begin
                xq[i] <= '0;
            end
        end else if (en) begin
            xq[0] <= din;
            for (int i = 1; i < 4; i++) begin
                xq[i] <= xq[i-1];
            end
        end
    end

endmodule

// File: rtl/hbf7_interp2.sv
// 2x half-band interpolator: one input sample in, an even then an odd output sample out.
// Polyphase: 4-tap even branch, single 64-weight odd branch.
module hbf7_interp2
    import hbf7_pkg::*;
#(
    parameter int unsigned DW    = 8,
    parameter int unsigned OW    = 16,
    parameter int unsigned SHIFT = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [DW-1:0] in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [OW-1:0] out_data
);

    localparam int unsigned PW = DW + 8;

    hbf7_state_e         state;
    logic                accept;
    logic signed [DW-1:0] xq [4];
    logic signed [PW-1:0] p_new, p_x1, p_x2, p_x3, p_odd;
    logic signed [OW-1:0] even_sum, odd_sum, even_out, odd_out;
    logic                unused_x3;

    assign accept = in_valid & in_ready;

    always_comb begin
        in_ready = 1'b0;
        unique case (state)
            IDLE:    in_ready = 1'b1;
            EVEN:    in_ready = 1'b0;
            ODD:     in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    hbf7_tap_line #(
        .DW(DW)
    ) u_tap (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (accept),
        .din  (in_data),
        .xq   (xq)
    );

    // Even sum is formed from the line as it will look after this accept:
    // in_data becomes x[n], xq[0..2] become x[n-1..n-3].
    assign p_new = PW'(HB_C0) * PW'(in_data);
    assign p_x1  = PW'(HB_C2) * PW'(xq[0]);
    assign p_x2  = PW'(HB_C2) * PW'(xq[1]);
    assign p_x3  = PW'(HB_C0) * PW'(xq[2]);
    assign even_sum = OW'(p_new) + OW'(p_x1) + OW'(p_x2) + OW'(p_x3);

    // Odd sample is loaded while in EVEN, after the shift, so xq[1] is x[n-1].
    assign p_odd   = PW'(HB_C3) * PW'(xq[1]);
    assign odd_sum = OW'(p_odd);

    assign even_out = even_sum >>> SHIFT;
    assign odd_out  = odd_sum >>> SHIFT;

    // Oldest tap is not needed by the interpolator phases.
    assign unused_x3 = ^xq[3];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        out_data  <= even_out;
                        out_valid <= 1'b1;
                        state     <= EVEN;
                    end
                end
                EVEN: begin
                    if (out_ready) begin
                        out_data <= odd_out;
                        state    <= ODD;
                    end
                end
                ODD: begin
                    if (out_ready) begin
                        if (accept) begin
                            out_data <= even_out;
                            state    <= EVEN;
                        end else begin
                            out_valid <= 1'b0;
                            state     <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hbf7_interp2.sv
// Scoreboard bench for hbf7_interp2: SHIFT=0 and SHIFT=6 instances share one stimulus stream.
module tb_hbf7_interp2;

    typedef int vec6_t[6];
    typedef int vec12_t[12];

    logic               clk;
    logic               rst_n;
    logic               in_valid;
    logic signed [7:0]  in_data;
    logic               out_ready;
    logic               in_ready0, in_ready6;
    logic               out_valid0, out_valid6;
    logic signed [15:0] out_data0, out_data6;

    int n_cmp = 0;
    int n_bad = 0;
    int q0[$];
    int q6[$];
    int e_mon;
    bit gap_on = 0;
    int gaps = 0;

    hbf7_interp2 #(.DW(8), .OW(16), .SHIFT(0)) dut0 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready0),
        .in_data  (in_data),
        .out_valid(out_valid0),
        .out_ready(out_ready),
        .out_data (out_data0)
    );

    hbf7_interp2 #(.DW(8), .OW(16), .SHIFT(6)) dut6 (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready6),
        .in_data  (in_data),
        .out_valid(out_valid6),
        .out_ready(out_ready),
        .out_data (out_data6)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push_exp(input int v);
        int v6;
        v6 = v >>> 6;
        q0.push_back(v);
        q6.push_back(v6);
    endtask

    // Monitor: inputs only move #1 after posedge, so negedge values equal the next edge's.
    always @(negedge clk) begin
        if (rst_n) begin
            if (gap_on && !out_valid0) gaps++;
            if (out_valid0 && out_ready) begin
                if (q0.size() == 0) check("dut0_unexpected_output", 1, 0);
                else begin
                    e_mon = q0.pop_front();
                    check("dut0_out_data", int'(out_data0), e_mon);
                end
            end
            if (out_valid6 && out_ready) begin
                if (q6.size() == 0) check("dut6_unexpected_output", 1, 0);
                else begin
                    e_mon = q6.pop_front();
                    check("dut6_out_data", int'(out_data6), e_mon);
                end
            end
        end
    end

    task automatic send(input int x, output int stalls);
        bit got;
        got    = 0;
        stalls = 0;
        in_valid = 1'b1;
        in_data  = 8'(x);
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (in_ready0) begin
                got = 1;
                break;
            end
            stalls++;
        end
        if (!got) check("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        for (int i = 0; i < 200; i++) begin
            if (q0.size() == 0 && q6.size() == 0 && !out_valid0 && !out_valid6) break;
            @(negedge clk);
        end
        check("drain_pending", q0.size() + q6.size(), 0);
        check("drain_idle_valid", int'(out_valid0), 0);
    endtask

    task automatic do_reset();
        in_valid  = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("rst_out_valid0", int'(out_valid0), 0);
        check("rst_out_valid6", int'(out_valid6), 0);
        check("rst_out_data0", int'(out_data0), 0);
        check("rst_out_data6", int'(out_data6), 0);
        q0.delete();
        q6.delete();
        out_ready = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("rst_in_ready0", int'(in_ready0), 1);
        check("rst_in_ready6", int'(in_ready6), 1);
    endtask

    task automatic run_seq(input vec6_t xs, input vec12_t es, input bit rate);
        int st;
        foreach (es[i]) push_exp(es[i]);
        out_ready = 1'b1;
        gaps = 0;
        for (int i = 0; i < 6; i++) begin
            send(xs[i], st);
            if (rate && i > 0) check("in_ready_toggle_stalls", st, 1);
            if (rate && i == 0) gap_on = 1;
        end
        gap_on   = 0;
        in_valid = 1'b0;
        drain();
        if (rate) check("out_valid_gaps", gaps, 0);
    endtask

    vec6_t  imp_in  = '{64, 0, 0, 0, 0, 0};
    vec12_t imp_exp = '{-128, 0, 2176, 4096, 2176, 0, -128, 0, 0, 0, 0, 0};
    vec6_t  ramp_in = '{1, 2, 3, 4, 5, 6};
    vec12_t ramp_exp = '{-2, 0, 30, 64, 96, 128, 160, 192, 224, 256, 288, 320};
    vec6_t  neg_in  = '{-128, -128, -128, -128, -128, -128};
    vec12_t neg_exp = '{256, 0, -4096, -8192, -8448, -8192,
                        -8192, -8192, -8192, -8192, -8192, -8192};
    vec6_t  pos_in  = '{127, 127, 127, 127, 127, 127};
    vec12_t pos_exp = '{-254, 0, 4064, 8128, 8382, 8128,
                        8128, 8128, 8128, 8128, 8128, 8128};

    initial begin
        int st;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        #12;

        // Impulse (SHIFT=6 instance covers the scaled expectations)
        do_reset();
        run_seq(imp_in, imp_exp, 1'b0);

        // Full-rate ramp
        do_reset();
        run_seq(ramp_in, ramp_exp, 1'b1);

        // Backpressure while holding the even sample
        do_reset();
        foreach (imp_exp[i]) push_exp(imp_exp[i]);
        out_ready = 1'b0;
        send(64, st);
        in_data = 8'sd0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("hold_out_valid", int'(out_valid0), 1);
            check("hold_out_data0", int'(out_data0), -128);
            check("hold_out_data6", int'(out_data6), -2);
            check("hold_in_ready", int'(in_ready0), 0);
            check("hold_tap0", int'(dut0.u_tap.xq[0]), 64);
            check("hold_tap1", int'(dut0.u_tap.xq[1]), 0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 1; i < 6; i++) send(0, st);
        in_valid = 1'b0;
        drain();

        // Extremes
        do_reset();
        run_seq(neg_in, neg_exp, 1'b0);
        do_reset();
        run_seq(pos_in, pos_exp, 1'b0);

        // Reset while presenting the odd sample
        do_reset();
        push_exp(-128);
        push_exp(0);
        send(64, st);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("mid_odd_out_valid", int'(out_valid0), 1);
        check("mid_odd_out_data", int'(out_data0), 0);
        #2;
        do_reset();
        run_seq(imp_in, imp_exp, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
